// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/controller for the single-port dmem shared by the load and store-commit units.
// Latency: accept N, memory cycle N+1, response N+2; one request per 2 cycles. Readies only in IDLE.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic [31:0]      ld_req_addr,
  input  logic [1:0]       ld_req_cs,
  input  logic             ld_req_signed,
  input  logic [TAG_W-1:0] ld_req_tag,
  output logic             ld_rsp_valid,
  output logic [31:0]      ld_rsp_data,
  output logic [TAG_W-1:0] ld_rsp_tag,
  output logic             ld_rsp_err,
  input  logic             st_req_valid,
  output logic             st_req_ready,
  input  logic [31:0]      st_req_addr,
  input  logic [1:0]       st_req_cs,
  input  logic [31:0]      st_req_data,
  output logic             st_done,
  output logic             st_err,
  output logic             mem_ena,
  output logic             mem_wena,
  output logic [1:0]       mem_w_cs,
  output logic [1:0]       mem_r_cs,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR} state_t;

  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  state_t           state, state_nxt;
  logic             last_st;
  logic             op_st;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [1:0]       r_cs;
  logic             r_sgn;
  logic [TAG_W-1:0] r_tag;

  logic        both_req, ld_acc, st_acc, acc_legal;
  logic [31:0] sel_addr, ld_ext;
  logic [1:0]  sel_cs;

  // 33-bit offset so addresses below BASE_ADDR show up as a borrow rather than wrapping
  function automatic logic req_legal(input logic [31:0] a, input logic [1:0] cs);
    logic [32:0] off;
    logic        aligned;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    case (cs)
      2'b01:   aligned = (a[1:0] == 2'b00);
      2'b10:   aligned = ~a[0];
      2'b11:   aligned = 1'b1;
      default: aligned = 1'b0;
    endcase
    return aligned && !off[32] && (off < RANGE_BYTES);
  endfunction

  // A flushed load does not count as a competing request
  assign both_req     = ld_req_valid & ~flush & st_req_valid;
  assign ld_req_ready = (state == S_IDLE) & ~flush & ~(both_req & ~last_st);
  assign st_req_ready = (state == S_IDLE) & ~(both_req & last_st);
  assign ld_acc       = ld_req_valid & ld_req_ready;
  assign st_acc       = st_req_valid & st_req_ready;
  assign sel_addr     = ld_acc ? ld_req_addr : st_req_addr;
  assign sel_cs       = ld_acc ? ld_req_cs : st_req_cs;
  assign acc_legal    = req_legal(sel_addr, sel_cs);

  always_comb begin
    state_nxt = S_IDLE;
    if (state == S_IDLE && (ld_acc || st_acc))
      state_nxt = acc_legal ? S_ACCESS : S_ERR;
  end

  always_comb begin
    case (r_cs)
      2'b10:   ld_ext = {{16{r_sgn & mem_rdata[15]}}, mem_rdata[15:0]};
      2'b11:   ld_ext = {{24{r_sgn & mem_rdata[7]}}, mem_rdata[7:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    mem_ena   = 1'b0;
    mem_wena  = 1'b0;
    mem_w_cs  = 2'b00;
    mem_r_cs  = 2'b00;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (state == S_ACCESS) begin
      mem_ena  = 1'b1;
      mem_addr = r_addr;
      if (op_st) begin
        mem_wena  = 1'b1;
        mem_w_cs  = r_cs;
        mem_wdata = r_data;
      end else begin
        mem_r_cs = r_cs;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      last_st <= 1'b1;
      op_st   <= 1'b0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_cs    <= 2'b00;
      r_sgn   <= 1'b0;
      r_tag   <= '0;
    end else begin
      state <= state_nxt;
      if (ld_acc || st_acc) begin
        op_st   <= st_acc;
        last_st <= st_acc;
        r_addr  <= sel_addr;
        r_cs    <= sel_cs;
        r_data  <= st_req_data;
        r_sgn   <= ld_req_signed;
        r_tag   <= ld_req_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rsp_valid <= 1'b0;
      ld_rsp_data  <= 32'h0;
      ld_rsp_tag   <= '0;
      ld_rsp_err   <= 1'b0;
      st_done      <= 1'b0;
      st_err       <= 1'b0;
    end else begin
      ld_rsp_valid <= 1'b0;
      ld_rsp_data  <= 32'h0;
      ld_rsp_tag   <= '0;
      ld_rsp_err   <= 1'b0;
      st_done      <= 1'b0;
      st_err       <= 1'b0;
      if (state != S_IDLE) begin
        if (op_st) begin
          st_done <= 1'b1;
          st_err  <= (state == S_ERR);
        end else if (!flush) begin
          ld_rsp_valid <= 1'b1;
          ld_rsp_err   <= (state == S_ERR);
          ld_rsp_data  <= (state == S_ACCESS) ? ld_ext : 32'h0;
          ld_rsp_tag   <= r_tag;
        end
      end
    end
  end

endmodule
